avalon_arbiter: RTL and testbench
=================================

Name: avalon_arbiter

Overview:
- Round-robin arbiter sharing one Avalon-MM master port between NUM_REQ load/store requesters, e.g. a data-side unit and a debug/peripheral unit.
- Sits between the requesters and the Avalon bus and sequences one basic, non-pipelined transfer at a time.
- Routes read data back to the requester that issued the read.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byteenable width is DATA_W/8.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- req_valid  input  NUM_REQ  requester i has a request; fields held stable until accepted
- req_ready  output  NUM_REQ  request i accepted this cycle (valid&ready = transfer)
- req_re  input  NUM_REQ  read request
- req_we  input  NUM_REQ  write request
- req_addr  input  NUM_REQ x ADDR_W  per-requester address
- req_be  input  NUM_REQ x DATA_W/8  per-requester byte enables
- req_wdata  input  NUM_REQ x DATA_W  per-requester write data
- resp_valid  output  NUM_REQ  one-cycle read-data pulse to requester i
- resp_data  output  DATA_W  read data, shared by all requesters
- m_addr  output  ADDR_W  Avalon address
- m_byteenable  output  DATA_W/8  Avalon byteenable
- m_writedata  output  DATA_W  Avalon write data
- m_read  output  1  Avalon read
- m_write  output  1  Avalon write
- m_waitrequest  input  1  Avalon waitrequest
- m_readdata  input  DATA_W  Avalon read data

Behaviour:
- Clock and reset: single clock clk. Reset rst is asynchronous and active-high.
- Reset values: all registers clear asynchronously.
  - FSM goes to IDLE.
  - m_read = m_write = 0; m_addr, m_byteenable, m_writedata = 0.
  - resp_valid = 0, resp_data = 0.
  - Round-robin pointer selects requester 0 as highest priority.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - req_ready is combinational and one-hot: set for the winner among req_valid, searching from (last_grant+1) mod NUM_REQ upward. All zero if no request. req_ready is always 0 in BUSY.
  - On acceptance:
    - Register the winner's addr, be and wdata onto m_*.
    - Set m_read = req_re or m_write = req_we.
    - Store the owner index; set last_grant to the winner; go to BUSY.
  - Request with re = we = 0: accepted, no bus cycle issued, stay IDLE.
  - Request with re = we = 1: read takes precedence.
- BUSY:
  - m_read/m_write held with address and data stable while m_waitrequest = 1.
  - On first cycle with m_waitrequest = 0: clear m_read/m_write and return to IDLE.
  - If it was a read: capture m_readdata into resp_data and pulse resp_valid[owner] the next cycle.
  - Writes produce no response.
- resp_data is 0 whenever resp_valid is all zero.
- Latency: accept at cycle N; m_read asserted at N+1; with zero wait, resp_valid at N+2. Next accept is possible at N+2, giving its bus cycle at N+3. Each wait cycle adds one cycle.
- Fairness: a requester holding valid continuously is served at most once per NUM_REQ grants while others are waiting. A lone requester is served back-to-back.
- Simultaneous events:
  - The response pulse for a finished read and a new acceptance may occur in the same cycle; both are required.
  - req_valid dropping without acceptance is legal and is ignored.
- Reset mid-transfer: the bus command drops immediately (asynchronously), the transfer is abandoned, and no resp_valid is issued.
- Invariants: at most one bit of req_ready and of resp_valid is set; m_read and m_write are never both 1.

Test Plan:
- Single read: req0 read addr 0x100, waitrequest = 0, readdata 0xDEADBEEF.
  - Required: m_read high exactly 1 cycle with m_addr = 0x100.
  - Required: resp_valid = 01 and resp_data = 0xDEADBEEF two cycles after acceptance.
- Wait states: req1 write addr 0x20, be 0x3, wdata 0x1234, waitrequest high 3 cycles.
  - Required: m_write high 4 cycles, fields stable throughout, no resp_valid.
  - Required: req_ready stays 0 until IDLE.
- Contention: req0 and req1 both valid with reads, held.
  - Required: grants alternate 0,1,0,1 after reset.
  - Required: each resp_valid goes to the correct index with distinct readdata 0xA0/0xB1.
- Back-to-back: req0 issues 3 reads alone, zero wait.
  - Required: m_read asserted at N+1, N+3, N+5.
  - Required: resp_valid at N+2, N+4, N+6.
- Reset during BUSY: assert rst while m_read = 1 and waitrequest = 1.
  - Required: m_read = 0 immediately, before the next clock; no resp_valid after reset release.
  - Required: first grant after reset goes to req0.
- Read priority: request with re = we = 1 gives m_read = 1, m_write = 0. Request with re = we = 0 is accepted with no bus activity.

Source files
------------

// File: rtl/avalon_arbiter_if.sv
// Bundles the requester-side handshake and the Avalon-MM master bus of avalon_arbiter.
// The arbiter uses the master modport; requesters and the Avalon slave use the slave modport.
interface avalon_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ-1:0]               req_re;
  logic [NUM_REQ-1:0]               req_we;
  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr;
  logic [NUM_REQ-1:0][DATA_W/8-1:0] req_be;
  logic [NUM_REQ-1:0][DATA_W-1:0]   req_wdata;
  logic [NUM_REQ-1:0]               resp_valid;
  logic [DATA_W-1:0]                resp_data;

  logic [ADDR_W-1:0]                m_addr;
  logic [DATA_W/8-1:0]              m_byteenable;
  logic [DATA_W-1:0]                m_writedata;
  logic                             m_read;
  logic                             m_write;
  logic                             m_waitrequest;
  logic [DATA_W-1:0]                m_readdata;

  modport master (
    input  req_valid, req_re, req_we, req_addr, req_be, req_wdata,
    input  m_waitrequest, m_readdata,
    output req_ready, resp_valid, resp_data,
    output m_addr, m_byteenable, m_writedata, m_read, m_write
  );

  modport slave (
    output req_valid, req_re, req_we, req_addr, req_be, req_wdata,
    output m_waitrequest, m_readdata,
    input  req_ready, resp_valid, resp_data,
    input  m_addr, m_byteenable, m_writedata, m_read, m_write
  );
endinterface

// File: rtl/avalon_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master port between NUM_REQ requesters,
// one non-pipelined transfer at a time, with read data routed back to its issuer.
module avalon_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  avalon_arbiter_if.master bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int BE_W  = DATA_W / 8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic                 m_read_q, m_read_d;
  logic                 m_write_q, m_write_d;
  logic [ADDR_W-1:0]    m_addr_q, m_addr_d;
  logic [BE_W-1:0]      m_be_q, m_be_d;
  logic [DATA_W-1:0]    m_wdata_q, m_wdata_d;
  logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]    resp_data_q, resp_data_d;

  logic [NUM_REQ-1:0]   req_ready_c;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_found;
  logic [IDX_W:0]       cand;

  // Search starts one past the last grant; last_grant < NUM_REQ keeps the wrap to one subtraction.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!grant_found && bus.req_valid[cand[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    m_read_d     = m_read_q;
    m_write_d    = m_write_q;
    m_addr_d     = m_addr_q;
    m_be_d       = m_be_q;
    m_wdata_d    = m_wdata_q;
    resp_valid_d = '0;
    resp_data_d  = '0;
    req_ready_c  = '0;

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready_c[grant_idx] = 1'b1;
          last_grant_d           = grant_idx;
          owner_d                = grant_idx;
          // A request with neither re nor we is consumed without touching the bus.
          if (bus.req_re[grant_idx] || bus.req_we[grant_idx]) begin
            m_read_d  = bus.req_re[grant_idx];
            m_write_d = !bus.req_re[grant_idx];
            m_addr_d  = bus.req_addr[grant_idx];
            m_be_d    = bus.req_be[grant_idx];
            m_wdata_d = bus.req_wdata[grant_idx];
            state_d   = BUSY;
          end
        end
      end
      BUSY: begin
        if (!bus.m_waitrequest) begin
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          state_d   = IDLE;
          if (m_read_q) begin
            resp_valid_d[owner_q] = 1'b1;
            resp_data_d           = bus.m_readdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset points last_grant at the top index so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      owner_q      <= '0;
      m_read_q     <= 1'b0;
      m_write_q    <= 1'b0;
      m_addr_q     <= '0;
      m_be_q       <= '0;
      m_wdata_q    <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      m_read_q     <= m_read_d;
      m_write_q    <= m_write_d;
      m_addr_q     <= m_addr_d;
      m_be_q       <= m_be_d;
      m_wdata_q    <= m_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign bus.req_ready    = req_ready_c;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_data    = resp_data_q;
  assign bus.m_addr       = m_addr_q;
  assign bus.m_byteenable = m_be_q;
  assign bus.m_writedata  = m_wdata_q;
  assign bus.m_read       = m_read_q;
  assign bus.m_write      = m_write_q;
endmodule

// File: tb/tb_avalon_arbiter.sv
// Directed testbench for avalon_arbiter: drives inputs on the falling edge and
// samples one time unit later, well away from the rising clock edge.
module tb_avalon_arbiter;
  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  avalon_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  avalon_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.req_valid     = '0;
    bus.req_re        = '0;
    bus.req_we        = '0;
    bus.req_addr      = '0;
    bus.req_be        = '0;
    bus.req_wdata     = '0;
    bus.m_waitrequest = 1'b0;
    bus.m_readdata    = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.m_read !== 1'b0) begin errors++; $display("[TB] FAIL rst_m_read got %b want 0", bus.m_read); end
    checks++; if (bus.m_write !== 1'b0) begin errors++; $display("[TB] FAIL rst_m_write got %b want 0", bus.m_write); end
    checks++; if (bus.m_addr !== 32'h0) begin errors++; $display("[TB] FAIL rst_m_addr got %h want 0", bus.m_addr); end
    checks++; if (bus.m_byteenable !== 4'h0 || bus.m_writedata !== 32'h0) begin errors++; $display("[TB] FAIL rst_m_be_wdata got %h/%h want 0/0", bus.m_byteenable, bus.m_writedata); end
    checks++; if (bus.resp_valid !== 2'b00) begin errors++; $display("[TB] FAIL rst_resp_valid got %b want 00", bus.resp_valid); end
    checks++; if (bus.resp_data !== 32'h0) begin errors++; $display("[TB] FAIL rst_resp_data got %h want 0", bus.resp_data); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("[TB] FAIL rst_ready_idle got %b want 00", bus.req_ready); end
  endtask

  task automatic test_single_read();
    @(negedge clk);
    bus.req_valid = 2'b01; bus.req_re = 2'b01; bus.req_we = 2'b00;
    bus.req_addr[0] = 32'h100; bus.m_waitrequest = 1'b0; bus.m_readdata = 32'hDEADBEEF;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL single_ready got %b want 01", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    checks++; if (bus.m_read !== 1'b1 || bus.m_write !== 1'b0) begin errors++; $display("[TB] FAIL single_m_read got rd=%b wr=%b want rd=1 wr=0", bus.m_read, bus.m_write); end
    checks++; if (bus.m_addr !== 32'h100) begin errors++; $display("[TB] FAIL single_m_addr got %h want 100", bus.m_addr); end
    checks++; if (bus.resp_valid !== 2'b00) begin errors++; $display("[TB] FAIL single_early_resp got %b want 00", bus.resp_valid); end
    @(negedge clk);
    #1;
    checks++; if (bus.m_read !== 1'b0) begin errors++; $display("[TB] FAIL single_m_read_drop got %b want 0", bus.m_read); end
    checks++; if (bus.resp_valid !== 2'b01) begin errors++; $display("[TB] FAIL single_resp_valid got %b want 01", bus.resp_valid); end
    checks++; if (bus.resp_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL single_resp_data got %h want deadbeef", bus.resp_data); end
    @(negedge clk);
    #1;
    checks++; if (bus.resp_valid !== 2'b00 || bus.resp_data !== 32'h0) begin errors++; $display("[TB] FAIL single_resp_clear got %b/%h want 00/0", bus.resp_valid, bus.resp_data); end
  endtask

  task automatic test_wait_states();
    @(negedge clk);
    bus.req_valid = 2'b10; bus.req_re = 2'b00; bus.req_we = 2'b10;
    bus.req_addr[1] = 32'h20; bus.req_be[1] = 4'h3; bus.req_wdata[1] = 32'h1234;
    bus.m_waitrequest = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("[TB] FAIL wait_accept got %b want 10", bus.req_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.req_valid = 2'b01; bus.req_re = 2'b01; bus.req_we = 2'b00; bus.req_addr[0] = 32'h200;
      bus.m_waitrequest = (i < 3);
      #1;
      checks++; if (bus.m_write !== 1'b1 || bus.m_read !== 1'b0) begin errors++; $display("[TB] FAIL wait_m_write cyc %0d got wr=%b rd=%b want wr=1 rd=0", i, bus.m_write, bus.m_read); end
      checks++; if (bus.m_addr !== 32'h20 || bus.m_byteenable !== 4'h3 || bus.m_writedata !== 32'h1234) begin errors++; $display("[TB] FAIL wait_fields cyc %0d got %h/%h/%h want 20/3/1234", i, bus.m_addr, bus.m_byteenable, bus.m_writedata); end
      checks++; if (bus.req_ready !== 2'b00 || bus.resp_valid !== 2'b00) begin errors++; $display("[TB] FAIL wait_busy cyc %0d got ready=%b resp=%b want 00/00", i, bus.req_ready, bus.resp_valid); end
    end
    @(negedge clk);
    bus.m_waitrequest = 1'b0; bus.m_readdata = 32'h55;
    #1;
    checks++; if (bus.m_write !== 1'b0 || bus.resp_valid !== 2'b00) begin errors++; $display("[TB] FAIL wait_end got wr=%b resp=%b want 0/00", bus.m_write, bus.resp_valid); end
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL wait_next_grant got %b want 01", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    checks++; if (bus.m_read !== 1'b1 || bus.m_addr !== 32'h200) begin errors++; $display("[TB] FAIL wait_followup_read got rd=%b addr=%h want 1/200", bus.m_read, bus.m_addr); end
    @(negedge clk);
    #1;
    checks++; if (bus.resp_valid !== 2'b01 || bus.resp_data !== 32'h55) begin errors++; $display("[TB] FAIL wait_followup_resp got %b/%h want 01/55", bus.resp_valid, bus.resp_data); end
  endtask

  task automatic test_contention();
    int g [4];
    g = '{0, 1, 0, 1};
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 2'b11; bus.req_re = 2'b11; bus.req_we = 2'b00;
    bus.req_addr[0] = 32'h40; bus.req_addr[1] = 32'h80;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++; if (bus.req_ready !== (2'b01 << g[i])) begin errors++; $display("[TB] FAIL cont_grant %0d got %b want %b", i, bus.req_ready, 2'b01 << g[i]); end
      if (i > 0) begin
        checks++; if (bus.resp_valid !== (2'b01 << g[i-1]) || bus.resp_data !== ((g[i-1] == 0) ? 32'hA0 : 32'hB1)) begin errors++; $display("[TB] FAIL cont_resp %0d got %b/%h", i, bus.resp_valid, bus.resp_data); end
      end
      @(negedge clk);
      #1;
      checks++; if (bus.m_read !== 1'b1 || bus.m_addr !== ((g[i] == 0) ? 32'h40 : 32'h80)) begin errors++; $display("[TB] FAIL cont_bus %0d got rd=%b addr=%h", i, bus.m_read, bus.m_addr); end
      bus.m_readdata = (bus.m_addr == 32'h40) ? 32'hA0 : 32'hB1;
    end
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    checks++; if (bus.resp_valid !== 2'b10 || bus.resp_data !== 32'hB1) begin errors++; $display("[TB] FAIL cont_last_resp got %b/%h want 10/b1", bus.resp_valid, bus.resp_data); end
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("[TB] FAIL cont_ready_idle got %b want 00", bus.req_ready); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp_ready [7];
    logic        exp_mread [7];
    logic [1:0]  exp_resp  [7];
    logic [31:0] exp_data  [7];
    logic [31:0] rd        [7];
    exp_ready = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00};
    exp_mread = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_resp  = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
    exp_data  = '{32'h0, 32'h0, 32'h11, 32'h0, 32'h22, 32'h0, 32'h33};
    rd        = '{32'h0, 32'h11, 32'h0, 32'h22, 32'h0, 32'h33, 32'h0};
    bus.m_waitrequest = 1'b0;
    bus.req_re = 2'b01; bus.req_we = 2'b00; bus.req_addr[0] = 32'h500;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      bus.req_valid  = {1'b0, (c <= 4)};
      bus.m_readdata = rd[c];
      #1;
      checks++; if (bus.req_ready !== exp_ready[c] || bus.m_read !== exp_mread[c]) begin errors++; $display("[TB] FAIL b2b_ctrl N+%0d got ready=%b rd=%b want %b/%b", c, bus.req_ready, bus.m_read, exp_ready[c], exp_mread[c]); end
      checks++; if (bus.resp_valid !== exp_resp[c] || bus.resp_data !== exp_data[c]) begin errors++; $display("[TB] FAIL b2b_resp N+%0d got %b/%h want %b/%h", c, bus.resp_valid, bus.resp_data, exp_resp[c], exp_data[c]); end
    end
  endtask

  task automatic test_reset_busy();
    @(negedge clk);
    bus.req_valid = 2'b01; bus.req_re = 2'b01; bus.req_we = 2'b00;
    bus.req_addr[0] = 32'h600; bus.m_waitrequest = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL rstbusy_accept got %b want 01", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    checks++; if (bus.m_read !== 1'b1) begin errors++; $display("[TB] FAIL rstbusy_m_read got %b want 1", bus.m_read); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (bus.m_read !== 1'b0 || bus.m_addr !== 32'h0) begin errors++; $display("[TB] FAIL rstbusy_async_drop got rd=%b addr=%h want 0/0", bus.m_read, bus.m_addr); end
    @(negedge clk);
    rst = 1'b0;
    bus.m_waitrequest = 1'b0; bus.m_readdata = 32'h99;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++; if (bus.resp_valid !== 2'b00 || bus.m_read !== 1'b0) begin errors++; $display("[TB] FAIL rstbusy_quiet %0d got resp=%b rd=%b want 00/0", i, bus.resp_valid, bus.m_read); end
    end
    @(negedge clk);
    bus.req_valid = 2'b11; bus.req_re = 2'b11; bus.req_addr[1] = 32'h700;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL rstbusy_first_grant got %b want 01", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read_priority();
    @(negedge clk);
    bus.req_valid = 2'b01; bus.req_re = 2'b01; bus.req_we = 2'b01;
    bus.req_addr[0] = 32'h300; bus.m_waitrequest = 1'b0; bus.m_readdata = 32'h77;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL prio_accept got %b want 01", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 2'b00; bus.req_re = 2'b00; bus.req_we = 2'b00;
    #1;
    checks++; if (bus.m_read !== 1'b1 || bus.m_write !== 1'b0) begin errors++; $display("[TB] FAIL prio_read_wins got rd=%b wr=%b want 1/0", bus.m_read, bus.m_write); end
    @(negedge clk);
    #1;
    checks++; if (bus.resp_valid !== 2'b01 || bus.resp_data !== 32'h77) begin errors++; $display("[TB] FAIL prio_resp got %b/%h want 01/77", bus.resp_valid, bus.resp_data); end
    @(negedge clk);
    bus.req_valid = 2'b10; bus.req_addr[1] = 32'h400;
    #1;
    checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("[TB] FAIL nop_accept got %b want 10", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 2'b01; bus.req_re = 2'b01;
    #1;
    checks++; if (bus.m_read !== 1'b0 || bus.m_write !== 1'b0) begin errors++; $display("[TB] FAIL nop_no_bus got rd=%b wr=%b want 0/0", bus.m_read, bus.m_write); end
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL nop_stays_idle got %b want 01", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    checks++; if (bus.m_read !== 1'b1 || bus.m_addr !== 32'h300) begin errors++; $display("[TB] FAIL nop_next_read got rd=%b addr=%h want 1/300", bus.m_read, bus.m_addr); end
    @(negedge clk);
    #1;
    checks++; if (bus.resp_valid !== 2'b01 || bus.resp_data !== 32'h77) begin errors++; $display("[TB] FAIL nop_next_resp got %b/%h want 01/77", bus.resp_valid, bus.resp_data); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_read();
    test_wait_states();
    test_contention();
    test_back_to_back();
    test_reset_busy();
    test_read_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
